// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C register responder.
//   i2c_state_t : protocol FSM states
//   ACK / NACK  : SDA level of the acknowledge bit
//   BYTE_W      : bits per I2C byte
package i2c_pkg;

  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_IGNORE,
    S_ACK_DEV,
    S_REG_HI,
    S_ACK_HI,
    S_REG_LO,
    S_ACK_LO,
    S_WR_DATA,
    S_ACK_WR,
    S_READ_DATA,
    S_M_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one open-drain I2C pad input.
//   2-FF synchroniser, then a stability filter that accepts a new level only
//   after FILTER_LEN consecutive identical samples, then edge pulses.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   line_i             : raw pad input
//   level              : filtered level (resets to 1, the idle bus level)
//   rise / fall        : one-cycle pulses, high the cycle after level changes
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [3:0] cnt;
  logic       level_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], line_i};
      level_d <= level;
      // Count samples that disagree with the accepted level; any agreeing
      // sample restarts the run, so short glitches never reach 'level'.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_reg_responder.sv
// i2c_reg_responder: I2C target with 7-bit device address, 16-bit register
// sub-address and 8-bit data, exposing each access on a parallel register port.
// Ports:
//   sys_clk, sys_rst_n : clock (>= 20x SCL), asynchronous active-low reset
//   scl_i, sda_i       : pad inputs
//   sda_oe             : 1 = pull SDA low
//   reg_addr           : current register address (auto-increments)
//   reg_wr_en/reg_wdata: one-cycle write strobe with data
//   reg_rd_en/reg_rdata: one-cycle read request; data sampled one cycle later
//   busy               : high from an addressed START until STOP
module i2c_reg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h2B,
  parameter int         FILTER_LEN = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam logic [3:0] LAST_BIT  = 4'(BYTE_W - 1);
  localparam logic [3:0] BITS_DONE = 4'(BYTE_W);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .line_i   (scl_i),
    .level    (scl_lvl),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .line_i   (sda_i),
    .level    (sda_lvl),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is a data change, not a condition.
  logic scl_quiet, start_det, stop_det;
  assign scl_quiet = ~scl_rise & ~scl_fall;
  assign start_det = scl_lvl & scl_quiet & sda_fall;
  assign stop_det  = scl_lvl & scl_quiet & sda_rise;

  i2c_state_t        state;
  logic [BYTE_W-1:0] shreg;
  logic [3:0]        bit_cnt;
  logic [7:0]        addr_hi;
  logic              rw;
  logic              drv_pend;

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_state, rx_last, rx_ack_due;
  assign rx_byte    = {shreg[BYTE_W-2:0], sda_lvl};
  assign rx_state   = state inside {S_DEV_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA};
  assign rx_last    = scl_rise && (bit_cnt == LAST_BIT);
  // The fall after the 8th bit opens the ACK slot.
  assign rx_ack_due = scl_fall && (bit_cnt == BITS_DONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      addr_hi   <= '0;
      rw        <= 1'b0;
      drv_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wr_en <= 1'b0;
      reg_wdata <= '0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      if (reg_wr_en) reg_addr <= reg_addr + 16'd1;

      if (start_det) begin
        state    <= S_DEV_ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        drv_pend <= 1'b0;
      end else if (stop_det) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        drv_pend <= 1'b0;
        busy     <= 1'b0;
      end else begin
        // Common receive path for every byte the master sends.
        if (rx_state && scl_rise && bit_cnt < BITS_DONE) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (rx_state && rx_ack_due) begin
          sda_oe  <= ~ACK;
          bit_cnt <= '0;
        end

        case (state)
          S_DEV_ADDR: begin
            if (rx_last) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                busy <= 1'b1;
                rw   <= rx_byte[0];
              end else begin
                state <= S_IGNORE;
              end
            end else if (rx_ack_due) begin
              state <= S_ACK_DEV;
            end
          end
          S_ACK_DEV: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              if (rw) begin
                state     <= S_READ_DATA;
                reg_rd_en <= 1'b1;
              end else begin
                state <= S_REG_HI;
              end
            end
          end
          S_REG_HI: begin
            if (rx_last)         addr_hi <= rx_byte;
            else if (rx_ack_due) state   <= S_ACK_HI;
          end
          S_ACK_HI: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= S_REG_LO;
            end
          end
          S_REG_LO: begin
            if (rx_last)         reg_addr <= {addr_hi, rx_byte};
            else if (rx_ack_due) state    <= S_ACK_LO;
          end
          S_ACK_LO, S_ACK_WR: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (rx_last) begin
              reg_wr_en <= 1'b1;
              reg_wdata <= rx_byte;
            end else if (rx_ack_due) begin
              state <= S_ACK_WR;
            end
          end
          S_READ_DATA: begin
            // Prefetch pipeline: rd_en -> latch reg_rdata -> drive MSB.
            if (reg_rd_en) begin
              shreg    <= reg_rdata;
              drv_pend <= 1'b1;
            end
            if (drv_pend) begin
              sda_oe   <= ~shreg[BYTE_W-1];
              drv_pend <= 1'b0;
            end
            if (scl_rise && bit_cnt < BITS_DONE) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == BITS_DONE) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= S_M_ACK;
              end else begin
                shreg  <= {shreg[BYTE_W-2:0], 1'b0};
                sda_oe <= ~shreg[BYTE_W-2];
              end
            end
          end
          S_M_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == NACK) state    <= S_IGNORE;
              else                 reg_addr <= reg_addr + 16'd1;
            end else if (scl_fall) begin
              state     <= S_READ_DATA;
              reg_rd_en <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_responder.sv
// tb_i2c_reg_responder: bit-banged I2C master driving i2c_reg_responder, with a
// register-file stub (read data = low address byte XOR rd_xor) and a
// transaction-level model of the auto-incrementing register pointer.
`timescale 1ns/1ps
module tb_i2c_reg_responder;
  import i2c_pkg::*;

  localparam int FILTER_LEN = 4;
  localparam int Q          = 12;   // quarter SCL period in sys_clk cycles

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        scl_pad   = 1'b1;
  logic        sda_pad   = 1'b1;
  logic        scl_i, sda_i, sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;
  logic [7:0]  rd_xor = 8'h00;

  assign scl_i     = scl_pad;
  assign sda_i     = sda_pad & ~sda_oe;
  assign reg_rdata = reg_addr[7:0] ^ rd_xor;

  i2c_reg_responder #(.DEV_ADDR(7'h2B), .FILTER_LEN(FILTER_LEN)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wr_en(reg_wr_en),
    .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic        oe_seen  = 1'b0;
  logic [15:0] m_addr   = 16'h0000;   // model of the register pointer

  always @(negedge sys_clk) begin
    if (reg_wr_en) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd_en) rd_q.push_back(reg_addr);
    if (sda_oe)    oe_seen = 1'b1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bus primitives ----------------
  task automatic wait_q();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    sda_pad = 1'b1; wait_q();
    scl_pad = 1'b1; wait_q();
    sda_pad = 1'b0; wait_q();
    scl_pad = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_pad = 1'b0; wait_q();
    scl_pad = 1'b1; wait_q();
    sda_pad = 1'b1; wait_q();
    wait_q();
  endtask

  // Optional glitch: SDA inverted for FILTER_LEN-1 cycles while SCL is high.
  task automatic send_bit(input logic b, input logic glitch);
    sda_pad = b; wait_q();
    scl_pad = 1'b1;
    if (glitch) begin
      repeat (2) @(negedge sys_clk);
      sda_pad = ~b;
      repeat (FILTER_LEN - 1) @(negedge sys_clk);
      sda_pad = b;
      repeat (2 * Q - 2 - (FILTER_LEN - 1)) @(negedge sys_clk);
    end else begin
      wait_q(); wait_q();
    end
    scl_pad = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_pad = 1'b1; wait_q();
    scl_pad = 1'b1; wait_q();
    b = sda_i;      wait_q();
    scl_pad = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic [7:0] gmask, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gmask[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic t;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(t);
      v = {v[6:0], t};
    end
    send_bit(nack, 1'b0);
  endtask

  // ---------------- transactions with inline checks ----------------
  task automatic write_txn(input logic [15:0] a, input logic [7:0] data[$],
                           input logic [7:0] gmask, input string tag);
    logic        ack;
    int          acks;
    logic [23:0] exp;
    acks = 0;
    wr_q.delete(); rd_q.delete();
    i2c_start();
    send_byte(8'h56, 8'h00, ack); if (ack == ACK) acks++;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_addr: got %b expected 1", tag, busy);
    end
    send_byte(a[15:8], 8'h00, ack); if (ack == ACK) acks++;
    send_byte(a[7:0],  8'h00, ack); if (ack == ACK) acks++;
    foreach (data[i]) begin
      send_byte(data[i], gmask, ack); if (ack == ACK) acks++;
    end
    i2c_stop();
    n_checks++;
    if (acks != 3 + data.size()) begin
      n_fail++; $display("FAIL %s ack_count: got %0d expected %0d", tag, acks, 3 + data.size());
    end
    n_checks++;
    if (wr_q.size() != data.size()) begin
      n_fail++; $display("FAIL %s wr_count: got %0d expected %0d", tag, wr_q.size(), data.size());
    end else begin
      foreach (data[i]) begin
        exp = {16'(a + 16'(i)), data[i]};
        n_checks++;
        if (wr_q[i] !== exp) begin
          n_fail++; $display("FAIL %s wr[%0d]: got %h expected %h", tag, i, wr_q[i], exp);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after_stop: got %b expected 0", tag, busy);
    end
    m_addr = 16'(a + 16'(data.size()));
  endtask

  task automatic read_txn(input logic with_sub, input logic [15:0] a, input int n,
                          input string tag);
    logic        ack;
    logic [7:0]  v, exp_b;
    logic [15:0] exp_a;
    int          acks;
    acks = 0;
    wr_q.delete(); rd_q.delete();
    i2c_start();
    if (with_sub) begin
      send_byte(8'h56,   8'h00, ack); if (ack == ACK) acks++;
      send_byte(a[15:8], 8'h00, ack); if (ack == ACK) acks++;
      send_byte(a[7:0],  8'h00, ack); if (ack == ACK) acks++;
      n_checks++;
      if (acks != 3) begin
        n_fail++; $display("FAIL %s sub_acks: got %0d expected 3", tag, acks);
      end
      m_addr = a;
      i2c_start();
    end
    send_byte(8'h57, 8'h00, ack);
    n_checks++;
    if (ack !== ACK) begin
      n_fail++; $display("FAIL %s rd_addr_ack: got %b expected %b", tag, ack, ACK);
    end
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, v);
      exp_a = 16'(m_addr + 16'(i));
      exp_b = exp_a[7:0] ^ rd_xor;
      n_checks++;
      if (v !== exp_b) begin
        n_fail++; $display("FAIL %s rd_byte[%0d]: got %h expected %h", tag, i, v, exp_b);
      end
    end
    i2c_stop();
    n_checks++;
    if (rd_q.size() != n || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s strobe_count: got rd=%0d wr=%0d expected rd=%0d wr=0",
               tag, rd_q.size(), wr_q.size(), n);
    end else begin
      foreach (rd_q[i]) begin
        exp_a = 16'(m_addr + 16'(i));
        n_checks++;
        if (rd_q[i] !== exp_a) begin
          n_fail++; $display("FAIL %s rd_addr[%0d]: got %h expected %h", tag, i, rd_q[i], exp_a);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after_stop: got %b expected 0", tag, busy);
    end
    m_addr = 16'(m_addr + 16'(n - 1));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({sda_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got oe=%b addr=%h wr=%b wd=%h rd=%b busy=%b expected all 0",
               sda_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy);
    end
    sys_rst_n = 1'b1;
    repeat (2 * Q) @(negedge sys_clk);
  endtask

  task automatic test_write_burst();
    write_txn(16'h1234, '{8'hA5, 8'h5A}, 8'h00, "write_burst");
  endtask

  task automatic test_read_burst();
    rd_xor = 8'h00;
    read_txn(1'b1, 16'h0010, 3, "read_burst");
  endtask

  task automatic test_bad_address();
    logic ack;
    wr_q.delete(); rd_q.delete(); oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h58, 8'h00, ack);
    n_checks++;
    if (ack !== NACK || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_addr_ack: got ack=%b busy=%b expected ack=1 busy=0", ack, busy);
    end
    send_byte(8'h12, 8'h00, ack);
    i2c_stop();
    n_checks++;
    if (oe_seen !== 1'b0 || wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_addr_quiet: got oe_seen=%b wr=%0d rd=%0d expected 0 0 0",
               oe_seen, wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_glitch();
    write_txn(16'h0040, '{8'hB4, 8'h3C}, 8'hC4, "glitch");
  endtask

  task automatic test_stop_mid_byte();
    logic       ack;
    logic [4:0] bits;
    bits = 5'b10110;
    wr_q.delete();
    i2c_start();
    send_byte(8'h56, 8'h00, ack);
    send_byte(8'h00, 8'h00, ack);
    send_byte(8'h20, 8'h00, ack);
    for (int i = 4; i >= 0; i--) send_bit(bits[i], 1'b0);
    i2c_stop();
    n_checks++;
    if (wr_q.size() != 0 || dut.state !== S_IDLE || sda_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_mid_byte: got wr=%0d state=%0d oe=%b busy=%b expected 0 IDLE 0 0",
               wr_q.size(), dut.state, sda_oe, busy);
    end
    m_addr = 16'h0020;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [15:0] a;
    for (int it = 0; it < 5; it++) begin
      if (it % 2 == 0) begin
        rd_xor = 8'($urandom);
        read_txn(1'b0, 16'h0000, $urandom_range(3, 1), "rand_rd");
      end else begin
        a = 16'($urandom);
        q.delete();
        repeat ($urandom_range(3, 1)) q.push_back(8'($urandom));
        write_txn(a, q, 8'h00, "rand_wr");
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic       ack;
    logic       seen;
    logic [7:0] q[$];
    rd_xor = 8'h00;   // byte 0x30: MSB 0, so the first bit pulls SDA low
    i2c_start();
    send_byte(8'h56, 8'h00, ack);
    send_byte(8'h00, 8'h00, ack);
    send_byte(8'h30, 8'h00, ack);
    i2c_start();
    send_byte(8'h57, 8'h00, ack);
    seen = 1'b0;
    for (int k = 0; k < 2 * Q && !seen; k++) begin
      if (sda_oe) seen = 1'b1;
      else @(negedge sys_clk);
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL rst_oe_driven: got %b expected 1", seen);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0 || reg_addr !== 16'h0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got oe=%b addr=%h busy=%b expected 0 0000 0", sda_oe, reg_addr, busy);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2 * Q) @(negedge sys_clk);
    i2c_stop();
    q.delete();
    q.push_back(8'($urandom));
    q.push_back(8'($urandom));
    write_txn(16'hFFFF, q, 8'h00, "wrap");
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_bad_address();
    test_glitch();
    test_stop_mid_byte();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
